// File: rtl/mips_cpu_load_writeback.sv
// MIPS load unit: accepts one load, performs a single word read on the data bus,
// then sign/zero-extends or merges (LWL/LWR) the result into the register file.
module mips_cpu_load_writeback (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [2:0]  ld_op,
  input  logic [31:0] ld_addr,
  input  logic [4:0]  ld_rt,
  input  logic [31:0] ld_rt_old,
  output logic        ld_done,
  output logic        ld_error,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic [3:0]  mem_byteenable,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata,
  output logic        wrEn,
  output logic [4:0]  wrAddr,
  output logic [31:0] wrData
);

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LWL = 3'b010;
  localparam logic [2:0] OP_LW  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_LHU = 3'b101;
  localparam logic [2:0] OP_LWR = 3'b110;
  localparam logic [2:0] OP_RSV = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [2:0]  r_op;
  logic [31:0] r_addr;
  logic [4:0]  r_rt;
  logic [31:0] r_rt_old;
  logic [31:0] r_data;
  logic        r_ld_error;

  logic        w_xfer;
  logic        w_bad;
  logic        w_accept;
  logic [1:0]  w_k;
  logic [4:0]  w_lsh;
  logic [4:0]  w_rsh;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_result;

  assign ld_ready = (r_state == S_IDLE);
  assign w_xfer   = ld_valid && ld_ready;
  assign w_accept = (r_state == S_READ) && !mem_waitrequest;

  // Alignment/opcode check is done on the incoming request so a bad load never touches the bus.
  always_comb begin
    w_bad = 1'b0;
    case (ld_op)
      OP_RSV:        w_bad = 1'b1;
      OP_LH, OP_LHU: w_bad = ld_addr[0];
      OP_LW:         w_bad = (ld_addr[1:0] != 2'b00);
      default:       w_bad = 1'b0;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_xfer && !w_bad) w_state_next = S_READ;
      S_READ:  if (!mem_waitrequest) w_state_next = S_WRITE;
      S_WRITE: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_op       <= 3'b000;
      r_addr     <= 32'h0;
      r_rt       <= 5'd0;
      r_rt_old   <= 32'h0;
      r_data     <= 32'h0;
      r_ld_error <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_ld_error <= w_xfer && w_bad;
      if (w_xfer) begin
        r_op     <= ld_op;
        r_addr   <= ld_addr;
        r_rt     <= ld_rt;
        r_rt_old <= ld_rt_old;
      end
      if (w_accept) r_data <= mem_readdata;
    end
  end

  // 3-k equals ~k for a 2-bit k, so the LWL shift is just the inverted byte lane.
  assign w_k    = r_addr[1:0];
  assign w_lsh  = {~w_k, 3'b000};
  assign w_rsh  = {w_k, 3'b000};
  assign w_byte = r_data[{w_k, 3'b000} +: 8];
  assign w_half = r_data[{r_addr[1], 4'b0000} +: 16];

  always_comb begin
    w_result = r_data;
    case (r_op)
      OP_LB:   w_result = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  w_result = {24'h0, w_byte};
      OP_LH:   w_result = {{16{w_half[15]}}, w_half};
      OP_LHU:  w_result = {16'h0, w_half};
      OP_LWL:  w_result = (r_data << w_lsh) | (r_rt_old & ~(32'hFFFF_FFFF << w_lsh));
      OP_LWR:  w_result = (r_data >> w_rsh) | (r_rt_old & ~(32'hFFFF_FFFF >> w_rsh));
      default: w_result = r_data;
    endcase
  end

  assign mem_read       = (r_state == S_READ);
  assign mem_address    = mem_read ? {r_addr[31:2], 2'b00} : 32'h0;
  assign mem_byteenable = mem_read ? 4'b1111 : 4'b0000;

  assign ld_done  = (r_state == S_WRITE);
  assign ld_error = r_ld_error;
  assign wrEn     = ld_done && (r_rt != 5'd0);
  assign wrAddr   = ld_done ? r_rt : 5'd0;
  assign wrData   = ld_done ? w_result : 32'h0;

endmodule
